// File: rtl/rr_sel10_pkg.sv
// Shared definitions for the 10-channel round-robin select generator.
// Holds the channel and select widths, the FSM state type and the one-hot helper.
package rr_sel10_pkg;

  localparam int NUM_CH = 10;
  localparam int SEL_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Indices 10..15 map to all-zeros, so no grant bit ever lands outside 0..9.
  function automatic logic [NUM_CH-1:0] onehot10(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick10.sv
// Combinational circular priority finder: returns the first requesting channel
// searching from last+1 (mod 10), so last itself is considered last of all.
module rr_pick10
  import rr_sel10_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              excl_en,
  input  logic [SEL_W-1:0]  excl,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  logic [NUM_CH-1:0] req_m;
  logic [SEL_W-1:0]  cand [NUM_CH];

  assign req_m = req & ~(excl_en ? onehot10(excl) : '0);

  // cand[k] is the k-th channel visited; the wrap 9 -> 0 is an explicit subtract.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      logic [SEL_W:0] sum;
      assign sum = {1'b0, last} + (SEL_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH))
                                                      : sum[SEL_W-1:0];
    end
  endgenerate

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_m[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/rr_sel10.sv
// Round-robin select generator driving the 10:1 mux select S, holding each grant
// for up to MAX_BURST transfers with a valid/ready handshake toward the consumer.
module rr_sel10
  import rr_sel10_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  S,
  output logic              sel_valid,
  output logic [NUM_CH-1:0] grant,
  output logic              burst_last
);

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] grant_q, grant_d;

  logic              in_grant, transfer, req_cur, exhausted, end_grant;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_last, pick_idx;

  assign in_grant  = (state_q == GRANT);
  assign transfer  = in_grant && out_ready;
  assign req_cur   = req[s_q];
  assign exhausted = transfer && (cnt_q == CNT_LAST);
  // A dropped request ends the grant whether or not a beat moved this cycle.
  assign end_grant = in_grant && (!req_cur || exhausted);
  assign pick_last = in_grant ? s_q : last_q;

  rr_pick10 u_pick (
    .req     (req),
    .last    (pick_last),
    .excl_en (exhausted),
    .excl    (s_q),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          s_d     = pick_idx;
          grant_d = onehot10(pick_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (end_grant) begin
          last_d = s_q;
          cnt_d  = '0;
          if (pick_any) begin
            s_d     = pick_idx;
            grant_d = onehot10(pick_idx);
          end else if (exhausted && req_cur) begin
            // Sole requester with an exhausted burst starts a fresh burst.
            s_d     = s_q;
            grant_d = grant_q;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (transfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign S          = s_q;
  assign sel_valid  = in_grant;
  assign grant      = grant_q;
  assign burst_last = in_grant && (cnt_q == CNT_LAST);

endmodule
